prienc_arbiter: RTL and testbench

//  Registered N-way request arbiter built on the priority-encoder idea. Picks one requester
//  per arbitration, holds the grant while the winner keeps requesting, and can force release

---
 rtl/prienc_pkg.sv | 33 +++
 rtl/prienc_arbiter_if.sv | 34 +++
 rtl/prienc_rr_pick.sv | 50 +++++
 rtl/prienc_arbiter.sv | 109 ++++++++++
 tb/tb_prienc_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prienc_pkg.sv
// Shared types and helpers for the priority-encoder arbiter.
//   arb_state_e : arbiter FSM state (IDLE, OWN)
//   onehot2idx  : one-hot vector (up to MAX_N bits) -> binary index
//   idx2onehot  : binary index -> one-hot vector (up to MAX_N bits)
// Callers slice the MAX_N-wide results down to their own N.
package prienc_pkg;

    localparam int MAX_N  = 32;
    localparam int MAX_IW = $clog2(MAX_N);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // OR-reduction of set bit positions; only meaningful for one-hot or zero input.
    function automatic logic [MAX_IW-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 32'(MAX_N); i++) begin
            if (oh[i]) idx = idx | MAX_IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAX_N-1:0] idx2onehot(input logic [MAX_IW-1:0] idx);
        logic [MAX_N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prienc_arbiter_if.sv
// Request/grant bundle between N request sources and the arbiter.
//   en        : arbitration enable (source side)
//   req[N]    : request vector (source side)
//   gnt[N]    : one-hot registered grant (arbiter side)
//   gnt_idx   : binary index of gnt, 0 when idle (arbiter side)
//   gnt_valid : |gnt (arbiter side)
// master = request sources, slave = arbiter.
interface prienc_arbiter_if #(
    parameter int N = 8
) ();
    localparam int IW = $clog2(N);

    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/prienc_rr_pick.sv
// Combinational masked priority pick.
//   v_i     : candidate vector
//   start_i : round-robin pointer; search starts at start_i-1 going down, wrapping
//   rr_en_i : 1 = round-robin search, 0 = plain highest-set-bit
//   oh_o    : one-hot winner (zero if v_i is zero)
//   idx_o   : binary winner index (zero if v_i is zero)
//   any_o   : v_i non-zero
module prienc_rr_pick
    import prienc_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  v_i,
    input  logic [IW-1:0] start_i,
    input  logic          rr_en_i,
    output logic [N-1:0]  oh_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0]   dbl;
    logic [MAX_N-1:0] oh32;
    int unsigned      top;
    int unsigned      hit;
    int unsigned      fold;

    // Doubling the vector makes the wrap a straight downward scan: bit j of
    // dbl stands for source j mod N. Scanning down from start+N-1 covers
    // start-1, ..., 0, N-1, ..., start exactly once, so masking everything
    // above that top position and taking the highest set bit gives the
    // round-robin winner. Fixed mode uses the top of the upper copy.
    always_comb begin
        dbl   = {v_i, v_i};
        top   = rr_en_i ? (32'(start_i) + 32'(N) - 32'd1) : (32'(2*N) - 32'd1);
        hit   = 0;
        any_o = 1'b0;
        for (int unsigned j = 0; j < 32'(2*N); j++) begin
            if (dbl[j] && (j <= top)) begin
                hit   = j;
                any_o = 1'b1;
            end
        end
        fold  = (hit >= 32'(N)) ? (hit - 32'(N)) : hit;
        oh32  = idx2onehot(MAX_IW'(fold));
        oh_o  = any_o ? oh32[N-1:0] : '0;
        idx_o = any_o ? IW'(onehot2idx(oh32)) : '0;
    end

endmodule

// File: rtl/prienc_arbiter.sv
// Registered N-way request arbiter.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   arb : request/grant bundle (slave side): en, req in; gnt, gnt_idx, gnt_valid out
// Grants one requester per arbitration and holds the grant while the owner keeps
// requesting. With MAX_HOLD>0 the owner is re-arbitrated against the others after
// MAX_HOLD consecutive cycles. RR_MODE selects fixed (MSB highest) or round-robin.
// All outputs are flops; request-to-grant latency is one cycle.
module prienc_arbiter
    import prienc_pkg::*;
#(
    parameter int N        = 8,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    prienc_arbiter_if.slave  arb
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e    state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_idx_q;
    logic          gnt_valid_q;
    logic [HW-1:0] hold_q;
    logic [IW-1:0] rr_ptr_q;

    logic          own_req;
    logic          expired;
    logic [N-1:0]  pick_v;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    // The owner's one-hot grant doubles as the exclusion mask when the budget
    // expires, so a single picker serves every arbitration case.
    always_comb begin
        own_req = arb.req[gnt_idx_q];
        expired = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1)) && own_req;
        pick_v  = arb.req;
        if (state_q == OWN && own_req) pick_v = arb.req & ~gnt_q;
    end

    prienc_rr_pick #(
        .N (N)
    ) u_pick (
        .v_i     (pick_v),
        .start_i (rr_ptr_q),
        .rr_en_i (RR_MODE != 0),
        .oh_o    (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            hold_q      <= '0;
            rr_ptr_q    <= IW'(N - 1);
        end else if (arb.en) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q     <= OWN;
                        gnt_q       <= pick_oh;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_q      <= '0;
                        rr_ptr_q    <= pick_idx;
                    end
                end
                OWN: begin
                    if (own_req && !expired) begin
                        // Unlimited budget leaves the counter at 0 so it never wraps.
                        if (MAX_HOLD != 0) hold_q <= hold_q + HW'(1);
                    end else if (pick_any) begin
                        gnt_q       <= pick_oh;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_q      <= '0;
                        rr_ptr_q    <= pick_idx;
                    end else if (own_req) begin
                        // Budget expired with no competitor: re-grant the owner.
                        hold_q   <= '0;
                        rr_ptr_q <= gnt_idx_q;
                    end else begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_idx_q   <= '0;
                        gnt_valid_q <= 1'b0;
                        hold_q      <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = gnt_idx_q;
    assign arb.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_prienc_arbiter.sv
// Directed bench for prienc_arbiter: four instances cover fixed/unlimited,
// round-robin with 1-cycle budget, fixed with 4-cycle budget and round-robin/unlimited.
module tb_prienc_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    prienc_arbiter_if #(.N(8)) if_fix ();
    prienc_arbiter_if #(.N(8)) if_rr1 ();
    prienc_arbiter_if #(.N(8)) if_h4  ();
    prienc_arbiter_if #(.N(8)) if_rr  ();

    prienc_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(0)) u_fix (.clk(clk), .rst(rst), .arb(if_fix));
    prienc_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(1)) u_rr1 (.clk(clk), .rst(rst), .arb(if_rr1));
    prienc_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(4)) u_h4  (.clk(clk), .rst(rst), .arb(if_h4));
    prienc_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(0)) u_rr  (.clk(clk), .rst(rst), .arb(if_rr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_fix.en = 1'b1; if_fix.req = '0;
        if_rr1.en = 1'b1; if_rr1.req = '0;
        if_h4.en  = 1'b1; if_h4.req  = '0;
        if_rr.en  = 1'b1; if_rr.req  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_fix got gnt=%h idx=%0d v=%b want 00/0/0", if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid);
        end
        n_cmp++;
        if ({if_rr1.gnt, if_rr1.gnt_idx, if_rr1.gnt_valid} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_rr1 got gnt=%h idx=%0d v=%b want 00/0/0", if_rr1.gnt, if_rr1.gnt_idx, if_rr1.gnt_valid);
        end
        n_cmp++;
        if ({if_h4.gnt, if_h4.gnt_idx, if_h4.gnt_valid} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_h4 got gnt=%h idx=%0d v=%b want 00/0/0", if_h4.gnt, if_h4.gnt_idx, if_h4.gnt_valid);
        end
        n_cmp++;
        if ({if_rr.gnt, if_rr.gnt_idx, if_rr.gnt_valid} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_rr got gnt=%h idx=%0d v=%b want 00/0/0", if_rr.gnt, if_rr.gnt_idx, if_rr.gnt_valid);
        end
    endtask

    // Two simultaneous requests, fixed priority, then release to idle.
    task automatic test_basic();
        do_reset();
        if_fix.req = 8'b0010_0100;
        step();
        if_fix.req = '0;
        n_cmp++;
        if (if_fix.gnt !== 8'b0010_0000 || if_fix.gnt_idx !== 3'd5 || if_fix.gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_grant got gnt=%h idx=%0d v=%b want 20/5/1", if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid);
        end
        step();
        n_cmp++;
        if (if_fix.gnt !== 8'h00 || if_fix.gnt_idx !== 3'd0 || if_fix.gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release got gnt=%h idx=%0d v=%b want 00/0/0", if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid);
        end
    endtask

    // Owner holds under full request, then hands over back-to-back.
    task automatic test_back_to_back();
        do_reset();
        if_fix.req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (if_fix.gnt !== 8'h80 || if_fix.gnt_idx !== 3'd7 || if_fix.gnt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL hold_msb cycle %0d got gnt=%h idx=%0d want 80/7", i, if_fix.gnt, if_fix.gnt_idx);
            end
        end
        if_fix.req = 8'h7F;
        step();
        n_cmp++;
        if (if_fix.gnt !== 8'h40 || if_fix.gnt_idx !== 3'd6 || if_fix.gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL handover got gnt=%h idx=%0d v=%b want 40/6/1", if_fix.gnt, if_fix.gnt_idx, if_fix.gnt_valid);
        end
    endtask

    // Round-robin with a one-cycle budget rotates every cycle.
    task automatic test_rr_rotate();
        logic [2:0] exp_idx [10] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
        logic [7:0] exp_oh;
        do_reset();
        if_rr1.req = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_oh = 8'd1 << exp_idx[i];
            n_cmp++;
            if (if_rr1.gnt_idx !== exp_idx[i] || if_rr1.gnt !== exp_oh || if_rr1.gnt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rr_rotate step %0d got idx=%0d gnt=%h want idx=%0d gnt=%h", i, if_rr1.gnt_idx, if_rr1.gnt, exp_idx[i], exp_oh);
            end
        end
    endtask

    // Budget of 4: lone owner is re-granted seamlessly; a competitor wins at expiry.
    task automatic test_hold_budget();
        do_reset();
        if_h4.req = 8'h01;
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if (if_h4.gnt !== 8'h01 || if_h4.gnt_idx !== 3'd0 || if_h4.gnt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL budget_lone edge %0d got gnt=%h idx=%0d want 01/0", i, if_h4.gnt, if_h4.gnt_idx);
            end
        end
        // The re-grant happened on the last edge, so three more edges stay with idx 0.
        if_h4.req = 8'h09;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (if_h4.gnt !== 8'h01 || if_h4.gnt_idx !== 3'd0) begin
                n_err++;
                $display("FAIL budget_nopreempt edge %0d got gnt=%h idx=%0d want 01/0", i, if_h4.gnt, if_h4.gnt_idx);
            end
        end
        step();
        n_cmp++;
        if (if_h4.gnt !== 8'h08 || if_h4.gnt_idx !== 3'd3 || if_h4.gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL budget_expiry got gnt=%h idx=%0d want 08/3", if_h4.gnt, if_h4.gnt_idx);
        end
    endtask

    // en=0 freezes the grant even though the request has gone.
    task automatic test_enable_freeze();
        do_reset();
        if_fix.req = 8'h04;
        step();
        n_cmp++;
        if (if_fix.gnt !== 8'h04 || if_fix.gnt_idx !== 3'd2) begin
            n_err++;
            $display("FAIL freeze_grant got gnt=%h idx=%0d want 04/2", if_fix.gnt, if_fix.gnt_idx);
        end
        if_fix.req = '0;
        if_fix.en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (if_fix.gnt !== 8'h04 || if_fix.gnt_idx !== 3'd2 || if_fix.gnt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL freeze_hold cycle %0d got gnt=%h idx=%0d want 04/2", i, if_fix.gnt, if_fix.gnt_idx);
            end
        end
        if_fix.en = 1'b1;
        step();
        n_cmp++;
        if (if_fix.gnt !== 8'h00 || if_fix.gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_release got gnt=%h v=%b want 00/0", if_fix.gnt, if_fix.gnt_valid);
        end
    endtask

    // Asynchronous reset mid-grant, then first pick uses the reset pointer.
    task automatic test_async_reset();
        do_reset();
        if_rr.req = 8'h10;
        step();
        n_cmp++;
        if (if_rr.gnt !== 8'h10 || if_rr.gnt_idx !== 3'd4) begin
            n_err++;
            $display("FAIL areset_setup got gnt=%h idx=%0d want 10/4", if_rr.gnt, if_rr.gnt_idx);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (if_rr.gnt !== 8'h00 || if_rr.gnt_valid !== 1'b0 || if_rr.gnt_idx !== 3'd0) begin
            n_err++;
            $display("FAIL areset_clear got gnt=%h idx=%0d v=%b want 00/0/0", if_rr.gnt, if_rr.gnt_idx, if_rr.gnt_valid);
        end
        #1 rst = 1'b0;
        if_rr.req  = 8'hFF;
        if_fix.req = 8'hFF;
        step();
        n_cmp++;
        if (if_rr.gnt !== 8'h40 || if_rr.gnt_idx !== 3'd6 || if_rr.gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_rr_first got gnt=%h idx=%0d want 40/6", if_rr.gnt, if_rr.gnt_idx);
        end
        n_cmp++;
        if (if_fix.gnt !== 8'h80 || if_fix.gnt_idx !== 3'd7) begin
            n_err++;
            $display("FAIL areset_fix_first got gnt=%h idx=%0d want 80/7", if_fix.gnt, if_fix.gnt_idx);
        end
        step();
        n_cmp++;
        if (if_rr.gnt !== 8'h40 || if_rr.gnt_idx !== 3'd6) begin
            n_err++;
            $display("FAIL rr_unlimited_hold got gnt=%h idx=%0d want 40/6", if_rr.gnt, if_rr.gnt_idx);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_rr_rotate();
        test_hold_budget();
        test_enable_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
